// File: rtl/welford_tuple_packer_if.sv
// Record-in / tuple-out handshake bundle for welford_tuple_packer.
// master drives records and out_ready; slave is the packer.
interface welford_tuple_packer_if #(
    parameter int COUNT_WIDTH     = 32,
    parameter int SCALING         = 32,
    parameter int DATAIN_WIDTH    = 11,
    parameter int RES_SHORT_WIDTH = 24,
    parameter int RES_LONG_WIDTH  = 40,
    parameter int DELTA_SCALING   = 18 - DATAIN_WIDTH - 1,
    parameter int OUTPUT_WIDTH    = 3*RES_SHORT_WIDTH + RES_LONG_WIDTH
);
    logic                                      in_valid;
    logic                                      in_ready;
    logic [COUNT_WIDTH-1:0]                    syn_count;
    logic [COUNT_WIDTH-1:0]                    pkt_count;
    logic [DATAIN_WIDTH+SCALING-1:0]           mean;
    logic [RES_LONG_WIDTH+2*DELTA_SCALING:0]   m2;
    logic                                      out_valid;
    logic                                      out_ready;
    logic [OUTPUT_WIDTH-1:0]                   tuple_out;
    logic [4:0]                                sat_flags;
    logic [15:0]                               sat_count;

    modport master (
        output in_valid, syn_count, pkt_count, mean, m2, out_ready,
        input  in_ready, out_valid, tuple_out, sat_flags, sat_count
    );

    modport slave (
        input  in_valid, syn_count, pkt_count, mean, m2, out_ready,
        output in_ready, out_valid, tuple_out, sat_flags, sat_count
    );
endinterface

// File: rtl/welford_tuple_packer.sv
// Packs one Welford statistics record per handshake into a saturated {syn, pkt, mean, m2} tuple.
// Latency: 2 cycles (S1 compute register, S2 output register); 1 record/cycle sustained.
// Backpressure: buffers up to 2 records while out_ready is low; in_ready drops only when S1 and S2 are both full.
module welford_tuple_packer #(
    parameter int COUNT_WIDTH     = 32,
    parameter int SCALING         = 32,
    parameter int DATAIN_WIDTH    = 11,
    parameter int RES_SHORT_WIDTH = 24,
    parameter int RES_LONG_WIDTH  = 40,
    parameter int DELTA_SCALING   = 18 - DATAIN_WIDTH - 1,
    parameter bit ROUND_EN        = 1'b1,
    parameter int OUTPUT_WIDTH    = 3*RES_SHORT_WIDTH + RES_LONG_WIDTH
) (
    input logic                   clk_lookup,
    input logic                   rst,
    welford_tuple_packer_if.slave bus
);
    localparam int MEAN_W = DATAIN_WIDTH + SCALING;
    localparam int M2_W   = RES_LONG_WIDTH + 2*DELTA_SCALING + 1;
    localparam int FRAC2  = 2*DELTA_SCALING;
    // Counts are widened so the overflow test works even when COUNT_WIDTH <= RES_SHORT_WIDTH.
    localparam int CNT_XW = (COUNT_WIDTH > RES_SHORT_WIDTH) ? COUNT_WIDTH : RES_SHORT_WIDTH + 1;

    typedef struct packed {
        logic [RES_SHORT_WIDTH-1:0] syn;
        logic [RES_SHORT_WIDTH-1:0] pkt;
        logic [RES_SHORT_WIDTH-1:0] mean;
        logic [RES_LONG_WIDTH-1:0]  m2;
    } tuple_t;

    tuple_t                  c_dat, s1_dat, s2_dat;
    logic [4:0]              c_flags, s1_flags, s2_flags;
    logic                    s1_vld, s2_vld;
    logic                    s1_load, s2_load, in_rdy;
    logic [15:0]             sat_cnt;

    logic [CNT_XW-1:0]       syn_x, pkt_x;
    logic [DATAIN_WIDTH:0]   mean_sum;
    logic [RES_LONG_WIDTH:0] m2_sum;
    logic                    m2_neg;

    always_comb begin
        c_dat    = '0;
        c_flags  = '0;
        syn_x    = CNT_XW'(bus.syn_count);
        pkt_x    = CNT_XW'(bus.pkt_count);
        mean_sum = {1'b0, bus.mean[MEAN_W-1:SCALING]}
                 + (DATAIN_WIDTH+1)'(ROUND_EN & bus.mean[SCALING-1]);
        m2_sum   = {1'b0, bus.m2[M2_W-2:FRAC2]}
                 + (RES_LONG_WIDTH+1)'(ROUND_EN & bus.m2[FRAC2-1]);
        m2_neg   = bus.m2[M2_W-1];

        c_flags[0] = |syn_x[CNT_XW-1:RES_SHORT_WIDTH];
        c_flags[1] = |pkt_x[CNT_XW-1:RES_SHORT_WIDTH];
        c_flags[2] = mean_sum[DATAIN_WIDTH];
        c_flags[3] = m2_neg;
        c_flags[4] = !m2_neg && m2_sum[RES_LONG_WIDTH];

        c_dat.syn  = c_flags[0] ? '1 : syn_x[RES_SHORT_WIDTH-1:0];
        c_dat.pkt  = c_flags[1] ? '1 : pkt_x[RES_SHORT_WIDTH-1:0];
        c_dat.mean = c_flags[2] ? RES_SHORT_WIDTH'({DATAIN_WIDTH{1'b1}})
                                : RES_SHORT_WIDTH'(mean_sum[DATAIN_WIDTH-1:0]);
        // A negative M2 is clamped before rounding, so it never reports saturation.
        if (m2_neg)
            c_dat.m2 = '0;
        else if (m2_sum[RES_LONG_WIDTH])
            c_dat.m2 = '1;
        else
            c_dat.m2 = m2_sum[RES_LONG_WIDTH-1:0];
    end

    assign s2_load = s1_vld && (!s2_vld || bus.out_ready);
    assign in_rdy  = !rst && (!s1_vld || !s2_vld || bus.out_ready);
    assign s1_load = bus.in_valid && in_rdy;

    always_ff @(posedge clk_lookup) begin
        if (rst) begin
            s1_vld   <= 1'b0;
            s2_vld   <= 1'b0;
            s1_dat   <= '0;
            s1_flags <= '0;
            s2_dat   <= '0;
            s2_flags <= '0;
            sat_cnt  <= '0;
        end else begin
            if (s1_load) begin
                s1_dat   <= c_dat;
                s1_flags <= c_flags;
                s1_vld   <= 1'b1;
            end else if (s2_load) begin
                s1_vld   <= 1'b0;
            end

            if (s2_load) begin
                s2_dat   <= s1_dat;
                s2_flags <= s1_flags;
                s2_vld   <= 1'b1;
            end else if (bus.out_ready) begin
                s2_vld   <= 1'b0;
            end

            if (s2_vld && bus.out_ready && (s2_flags != 5'd0) && (sat_cnt != 16'hFFFF))
                sat_cnt <= sat_cnt + 16'd1;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = s2_vld;
    assign bus.tuple_out = OUTPUT_WIDTH'(s2_dat);
    assign bus.sat_flags = s2_flags;
    assign bus.sat_count = sat_cnt;
endmodule

// File: tb/tb_welford_tuple_packer.sv
// Scoreboard bench: rounding and truncating packers run in lockstep against an arithmetic reference model.
module tb_welford_tuple_packer;
    localparam int CW  = 32;
    localparam int SC  = 32;
    localparam int DW  = 11;
    localparam int RSW = 24;
    localparam int RLW = 40;
    localparam int DS  = 18 - DW - 1;
    localparam int OW  = 3*RSW + RLW;
    localparam int MW  = DW + SC;
    localparam int M2W = RLW + 2*DS + 1;

    localparam longint unsigned SHORT_MAX = (64'd1 << RSW) - 64'd1;
    localparam longint unsigned MEAN_MAX  = (64'd1 << DW) - 64'd1;
    localparam longint unsigned LONG_MAX  = (64'd1 << RLW) - 64'd1;

    logic clk_lookup = 1'b0;
    logic rst        = 1'b1;
    always #5 clk_lookup = ~clk_lookup;

    welford_tuple_packer_if #(.COUNT_WIDTH(CW), .SCALING(SC), .DATAIN_WIDTH(DW), .RES_SHORT_WIDTH(RSW),
        .RES_LONG_WIDTH(RLW), .DELTA_SCALING(DS), .OUTPUT_WIDTH(OW)) bus_r ();
    welford_tuple_packer_if #(.COUNT_WIDTH(CW), .SCALING(SC), .DATAIN_WIDTH(DW), .RES_SHORT_WIDTH(RSW),
        .RES_LONG_WIDTH(RLW), .DELTA_SCALING(DS), .OUTPUT_WIDTH(OW)) bus_t ();

    welford_tuple_packer #(.COUNT_WIDTH(CW), .SCALING(SC), .DATAIN_WIDTH(DW), .RES_SHORT_WIDTH(RSW),
        .RES_LONG_WIDTH(RLW), .DELTA_SCALING(DS), .ROUND_EN(1'b1), .OUTPUT_WIDTH(OW))
        dut_r (.clk_lookup(clk_lookup), .rst(rst), .bus(bus_r));
    welford_tuple_packer #(.COUNT_WIDTH(CW), .SCALING(SC), .DATAIN_WIDTH(DW), .RES_SHORT_WIDTH(RSW),
        .RES_LONG_WIDTH(RLW), .DELTA_SCALING(DS), .ROUND_EN(1'b0), .OUTPUT_WIDTH(OW))
        dut_t (.clk_lookup(clk_lookup), .rst(rst), .bus(bus_t));

    typedef struct {
        logic [CW-1:0]  syn;
        logic [CW-1:0]  pkt;
        logic [MW-1:0]  mean;
        logic [M2W-1:0] m2;
    } rec_t;

    typedef struct {
        logic [OW-1:0] tuple;
        logic [4:0]    flags;
    } exp_t;

    exp_t          q_r[$];
    exp_t          q_t[$];
    int            sat_exp[2];
    bit            hold[2];
    logic [OW-1:0] hold_tup[2];
    int            checks = 0;
    int            errors = 0;
    bit            acc, ov;
    rec_t          idle_r, r;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: fields computed as real-valued rounding (add one half, floor) and clamping.
    function automatic exp_t model(input rec_t rc, input bit rnd);
        exp_t e;
        longint unsigned syn_f, pkt_f, mean_f, m2_f, half;
        e.flags = '0;
        syn_f = 64'(rc.syn);
        pkt_f = 64'(rc.pkt);
        if (syn_f > SHORT_MAX) begin syn_f = SHORT_MAX; e.flags[0] = 1'b1; end
        if (pkt_f > SHORT_MAX) begin pkt_f = SHORT_MAX; e.flags[1] = 1'b1; end
        half   = rnd ? (64'd1 << (SC - 1)) : 64'd0;
        mean_f = (64'(rc.mean) + half) >> SC;
        if (mean_f > MEAN_MAX) begin mean_f = MEAN_MAX; e.flags[2] = 1'b1; end
        if (rc.m2[M2W-1]) begin
            m2_f = 64'd0;
            e.flags[3] = 1'b1;
        end else begin
            half = rnd ? (64'd1 << (2*DS - 1)) : 64'd0;
            m2_f = (64'(rc.m2) + half) >> (2*DS);
            if (m2_f > LONG_MAX) begin m2_f = LONG_MAX; e.flags[4] = 1'b1; end
        end
        e.tuple = {syn_f[RSW-1:0], pkt_f[RSW-1:0], mean_f[RSW-1:0], m2_f[RLW-1:0]};
        return e;
    endfunction

    function automatic rec_t mk(input longint unsigned s, input longint unsigned p,
                                input longint unsigned m, input longint unsigned v);
        rec_t x;
        x.syn  = CW'(s);
        x.pkt  = CW'(p);
        x.mean = MW'(m);
        x.m2   = M2W'(v);
        return x;
    endfunction

    function automatic rec_t rand_rec();
        rec_t x;
        case ($urandom_range(0, 3))
            0:       x.syn = $urandom;
            1:       x.syn = 32'h00FF_FFFF + $urandom_range(0, 2);
            default: x.syn = $urandom & 32'h000F_FFFF;
        endcase
        case ($urandom_range(0, 3))
            0:       x.pkt = $urandom;
            1:       x.pkt = 32'h00FF_FFFF + $urandom_range(0, 2);
            default: x.pkt = $urandom & 32'h00FF_FFFF;
        endcase
        x.mean = MW'({$urandom, $urandom});
        if ($urandom_range(0, 3) == 0) x.mean = {11'h7FF, 32'($urandom)};
        case ($urandom_range(0, 3))
            0:       x.m2 = {1'b1, 52'({$urandom, $urandom})};
            1:       x.m2 = {1'b0, 40'hFF_FFFF_FFFF, 12'($urandom)};
            default: x.m2 = {1'b0, 52'({$urandom, $urandom})};
        endcase
        return x;
    endfunction

    task automatic drive(input bit v, input rec_t rc, input bit ordy);
        bus_r.in_valid  = v;
        bus_r.syn_count = rc.syn;
        bus_r.pkt_count = rc.pkt;
        bus_r.mean      = rc.mean;
        bus_r.m2        = rc.m2;
        bus_r.out_ready = ordy;
        bus_t.in_valid  = v;
        bus_t.syn_count = rc.syn;
        bus_t.pkt_count = rc.pkt;
        bus_t.mean      = rc.mean;
        bus_t.m2        = rc.m2;
        bus_t.out_ready = ordy;
    endtask

    // Called just after a rising edge; returns whether the record is taken at the next edge.
    task automatic cycle(input bit v, input rec_t rc, input bit ordy, output bit a, output bit o);
        drive(v, rc, ordy);
        #1;
        a = v && bus_r.in_ready;
        o = bus_r.out_valid;
        if (a) q_r.push_back(model(rc, 1'b1));
        if (v && bus_t.in_ready) q_t.push_back(model(rc, 1'b0));
        @(posedge clk_lookup);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((q_r.size() != 0 || q_t.size() != 0) && n < 50) begin
            cycle(1'b0, idle_r, 1'b1, acc, ov);
            n++;
        end
        repeat (2) cycle(1'b0, idle_r, 1'b1, acc, ov);
        checks++;
        if (q_r.size() != 0 || q_t.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d/%0d tuples still owed, expected 0", q_r.size(), q_t.size());
        end
    endtask

    task automatic mon(input int k, input logic o, input logic ordy, input logic [OW-1:0] tup,
                       input logic [4:0] fl, input logic [15:0] sc);
        exp_t e;
        bit   have;
        check($sformatf("sat_count[%0d]", k), 128'(sc), 128'(sat_exp[k]));
        if (hold[k]) begin
            check($sformatf("stall_valid[%0d]", k), 128'(o), 128'(1'b1));
            check($sformatf("stall_tuple[%0d]", k), 128'(tup), 128'(hold_tup[k]));
        end
        hold[k]     = o && !ordy;
        hold_tup[k] = tup;
        if (o && ordy) begin
            have = (k == 0) ? (q_r.size() != 0) : (q_t.size() != 0);
            if (!have) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tuple[%0d]: got %0h, expected no output", k, tup);
            end else begin
                if (k == 0) e = q_r.pop_front();
                else        e = q_t.pop_front();
                check($sformatf("tuple[%0d]", k), 128'(tup), 128'(e.tuple));
                check($sformatf("sat_flags[%0d]", k), 128'(fl), 128'(e.flags));
                if (e.flags != 5'd0 && sat_exp[k] < 65535) sat_exp[k]++;
            end
        end
    endtask

    always @(negedge clk_lookup) begin
        if (rst) begin
            hold[0] = 1'b0;
            hold[1] = 1'b0;
        end else begin
            mon(0, bus_r.out_valid, bus_r.out_ready, bus_r.tuple_out, bus_r.sat_flags, bus_r.sat_count);
            mon(1, bus_t.out_valid, bus_t.out_ready, bus_t.tuple_out, bus_t.sat_flags, bus_t.sat_count);
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pending;
        idle_r     = mk(0, 0, 0, 0);
        sat_exp[0] = 0;
        sat_exp[1] = 0;
        rst = 1'b1;
        drive(1'b0, idle_r, 1'b0);
        repeat (2) @(posedge clk_lookup);
        #1;
        check("rst_out_valid", 128'(bus_r.out_valid), 128'(0));
        check("rst_tuple", 128'(bus_r.tuple_out), 128'(0));
        check("rst_flags", 128'(bus_r.sat_flags), 128'(0));
        check("rst_sat_count", 128'(bus_r.sat_count), 128'(0));
        check("rst_in_ready", 128'(bus_r.in_ready), 128'(0));
        rst = 1'b0;
        #1;
        check("in_ready_after_release", 128'(bus_r.in_ready), 128'(1));
        check("in_ready_after_release_t", 128'(bus_t.in_ready), 128'(1));

        // First record through an empty pipe: visible exactly two edges after acceptance.
        r = mk(5, 100, (64'd300 << 32) | 64'h8000_0000, (64'd1000 << 12) | 64'h800);
        cycle(1'b1, r, 1'b1, acc, ov);
        check("basic_accept", 128'(acc), 128'(1));
        cycle(1'b0, idle_r, 1'b1, acc, ov);
        check("latency_edge1_valid", 128'(ov), 128'(0));
        cycle(1'b0, idle_r, 1'b1, acc, ov);
        check("latency_edge2_valid", 128'(ov), 128'(1));

        cycle(1'b1, mk(64'h0100_0000, 7, (64'd2047 << 32) | 64'h8000_0000, 0), 1'b1, acc, ov);
        cycle(1'b1, mk(1, 2, 0, {M2W{1'b1}}), 1'b1, acc, ov);
        cycle(1'b1, mk(3, 4, 64'd1 << 31, (64'd1 << 52) - 64'd1), 1'b1, acc, ov);
        drain();

        // Backpressure: two records absorb, the third is refused until the consumer resumes.
        cycle(1'b1, rand_rec(), 1'b0, acc, ov);
        check("bp_accept_a", 128'(acc), 128'(1));
        cycle(1'b1, rand_rec(), 1'b0, acc, ov);
        check("bp_accept_b", 128'(acc), 128'(1));
        r = rand_rec();
        cycle(1'b1, r, 1'b0, acc, ov);
        check("bp_refuse_c", 128'(acc), 128'(0));
        cycle(1'b1, r, 1'b1, acc, ov);
        check("bp_accept_c", 128'(acc), 128'(1));
        check("bp_deliver_a", 128'(ov), 128'(1));
        cycle(1'b0, idle_r, 1'b1, acc, ov);
        check("bp_deliver_b", 128'(ov), 128'(1));
        cycle(1'b0, idle_r, 1'b1, acc, ov);
        check("bp_deliver_c", 128'(ov), 128'(1));
        cycle(1'b0, idle_r, 1'b1, acc, ov);
        check("bp_empty", 128'(ov), 128'(0));

        pending = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!pending) begin
                pending = ($urandom_range(0, 3) != 0);
                r = rand_rec();
            end
            cycle(pending, r, ($urandom_range(0, 9) < 6), acc, ov);
            if (acc) pending = 1'b0;
        end
        drain();

        // Reset with both stages holding records: everything in flight must vanish.
        cycle(1'b1, rand_rec(), 1'b0, acc, ov);
        cycle(1'b1, rand_rec(), 1'b0, acc, ov);
        check("prereset_full", 128'(bus_r.in_ready), 128'(0));
        rst = 1'b1;
        drive(1'b0, idle_r, 1'b0);
        @(posedge clk_lookup);
        #1;
        check("midrst_out_valid", 128'(bus_r.out_valid), 128'(0));
        check("midrst_sat_count", 128'(bus_r.sat_count), 128'(0));
        check("midrst_in_ready", 128'(bus_r.in_ready), 128'(0));
        q_r.delete();
        q_t.delete();
        sat_exp[0] = 0;
        sat_exp[1] = 0;
        rst = 1'b0;
        #1;
        check("postrst_in_ready", 128'(bus_r.in_ready), 128'(1));
        for (int i = 0; i < 20; i++) cycle(1'b1, rand_rec(), 1'b1, acc, ov);
        drain();

        for (int i = 0; i < 65540; i++) begin
            r = rand_rec();
            r.syn = 32'h0100_0000 | r.syn;
            cycle(1'b1, r, 1'b1, acc, ov);
        end
        drain();
        check("sat_count_clamped_r", 128'(bus_r.sat_count), 128'(16'hFFFF));
        check("sat_count_clamped_t", 128'(bus_t.sat_count), 128'(16'hFFFF));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/welford_tuple_packer.md
# welford_tuple_packer

Parametrised, pipelined successor to the Welford statistics concatenation stage. Takes one per-flow statistics record (SYN count, packet count, fixed-point mean, signed M2) per valid/ready handshake, saturates counts, rounds and saturates the mean and M2, packs the result into the output tuple, and reports per-field saturation flags and a running saturation counter. It sits between the Welford update datapath and the extern result bus.

## Interface
- COUNT_WIDTH, 32: width of the incoming count fields.
- SCALING, 32: fraction bits of `mean`.
- DATAIN_WIDTH, 11: integer bits of `mean`; must be ≤ RES_SHORT_WIDTH.
- RES_SHORT_WIDTH, 24: packed width of each of syn, pkt and mean fields.
- RES_LONG_WIDTH, 40: packed width of the M2 field.
- DELTA_SCALING, 18-DATAIN_WIDTH-1 (=6): M2 carries 2*DELTA_SCALING extra fraction bits; must be ≥1.
- ROUND_EN, 1: 1 = round-half-up on mean and M2; 0 = truncate.
- OUTPUT_WIDTH, 3*RES_SHORT_WIDTH+RES_LONG_WIDTH: tuple width.
- clk_lookup  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input record valid.
- in_ready  out  1  block accepts record this cycle.
- syn_count  in  COUNT_WIDTH  unsigned.
- pkt_count  in  COUNT_WIDTH  unsigned.
- mean  in  DATAIN_WIDTH+SCALING  unsigned fixed point.
- m2  in  RES_LONG_WIDTH+2*DELTA_SCALING+1  signed.
- out_valid  out  1  tuple valid.
- out_ready  in  1  consumer accepts tuple.
- tuple_out  out  OUTPUT_WIDTH  {syn, pkt, mean, m2}, syn in MSBs.
- sat_flags  out  5  per-tuple flags, aligned with tuple_out: [0] syn sat, [1] pkt sat, [2] mean sat, [3] m2 negative clamp, [4] m2 sat.
- sat_count  out  16  count of delivered tuples with any flag set.

## Operation
- Counts: value ≥ 2^RES_SHORT_WIDTH → all ones, set flag; else low RES_SHORT_WIDTH bits.
- Mean: int = mean[DATAIN_WIDTH+SCALING-1:SCALING]; if ROUND_EN add mean[SCALING-1]; carry out of DATAIN_WIDTH bits → int = all ones, flag[2]. Zero-extended to RES_SHORT_WIDTH.
- M2: negative → 0, flag[3], no rounding. Else v = m2[RES_LONG_WIDTH+2*DELTA_SCALING-1:2*DELTA_SCALING]; if ROUND_EN add m2[2*DELTA_SCALING-1]; carry out of RES_LONG_WIDTH → all ones, flag[4].
- Pipeline: S1 register (computed fields + flags), S2 output register (drives tuple_out, sat_flags, out_valid).
- s2_load = S1 valid && (!S2 valid || out_ready). s1_load = in_valid && in_ready.
- in_ready = !rst && (!S1 valid || !S2 valid || out_ready) (combinational from out_ready).
- Order preserved; no drop, no duplication.
- sat_count increments by 1 on each out_valid && out_ready with sat_flags ≠ 0; saturates at 16'hFFFF (no wrap).
- tuple_out/sat_flags hold stable while out_valid && !out_ready.

## Timing
- Latency: accept at cycle N → out_valid at N+2 if unstalled.
- Throughput: 1 record/cycle while out_ready high.
- Stall: with out_ready low, at most 2 records buffered; in_ready falls when both S1 and S2 full.
- Simultaneous out handshake and input accept with both stages full: S2 takes S1, S1 takes input, same cycle.
- Reset (any cycle, including mid-stream): next edge clears S1/S2 valid, tuple_out=0, sat_flags=0, sat_count=0, out_valid=0; in_ready=0 while rst high, 1 the cycle after release. In-flight records discarded.

## Test plan
- Basic, ROUND_EN=1: syn=5, pkt=100, mean=(300<<32)|32'h8000_0000, m2=(1000<<12)|12'h800 → 2 cycles later tuple_out={24'd5,24'd100,24'd301,40'd1001}, sat_flags=0.
- Saturation: syn=32'h0100_0000, mean=(2047<<32)|32'h8000_0000 → syn field 24'hFFFFFF, mean 24'd2047, sat_flags=5'b00101, sat_count=1 after handshake.
- M2 edge: m2=-1 → m2 field 0, flag[3]; m2=all-ones positive (2^52-1) → 40'hFF_FFFF_FFFF, flag[4]; ROUND_EN=0 same input → no flag[4].
- Backpressure: out_ready=0, offer A,B,C back-to-back → A,B accepted, in_ready=0 on C; raise out_ready → A,B,C delivered in order on consecutive cycles, no loss.
- Reset mid-stream: assert rst one cycle with S1,S2 full → out_valid=0, sat_count=0 next cycle; no stale tuple appears afterwards.
- Counter saturation: 65537 flagged tuples delivered → sat_count=16'hFFFF, stays there.
